// File: rtl/debug_display.sv
// Avalon-MM debug display: six 7-segment digits (hex or raw patterns) plus ten LEDs.
// Optional blink support is compiled in with `define DEBUG_DISPLAY_BLINK_EN.
module debug_display #(
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  address,
   input  logic        write,
   input  logic        read,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic [41:0] seg_conduit,
   output logic [9:0]  light_conduit
);

   logic [23:0] hex_q, hex_d;
   logic [12:0] ctrl_q, ctrl_d;
   logic [27:0] raw_lo_q, raw_lo_d;
   logic [13:0] raw_hi_q, raw_hi_d;
   logic [9:0]  ledr_q, ledr_d;
   logic [15:0] wcnt_q, wcnt_d;
   logic [31:0] readdata_q, readdata_d;
   logic [41:0] seg_q, seg_d;
   logic [31:0] lane_m;
   logic [31:0] rd_mux;
   logic [41:0] raw_all;
   logic [6:0]  pat;
   logic        phase_q, phase_d;

`ifdef DEBUG_DISPLAY_BLINK_EN
   localparam logic [12:0] CTRL_WMASK = 13'h1FFF;
   localparam logic [25:0] BLINK_LAST = 26'(BLINK_DIV - 1);
   logic [25:0] blink_cnt_q, blink_cnt_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q + 26'd1;
      phase_d     = phase_q;
      if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = 26'd0;
         phase_d     = ~phase_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt_q <= 26'd0;
         phase_q     <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
      end
   end
`else
   localparam logic [12:0] CTRL_WMASK = 13'h103F;
   localparam int unsigned UNUSED_BLINK_DIV = BLINK_DIV;
   assign phase_q = 1'b0;
   assign phase_d = 1'b0;
`endif

   wire unused_bits = &{1'b0, writedata[31:28], lane_m[31:28]};

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      lane_m   = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
      hex_d    = hex_q;
      ctrl_d   = ctrl_q;
      raw_lo_d = raw_lo_q;
      raw_hi_d = raw_hi_q;
      ledr_d   = ledr_q;
      wcnt_d   = wcnt_q;
      if (write) begin
         case (address)
            3'd0: hex_d    = (hex_q & ~lane_m[23:0]) | (writedata[23:0] & lane_m[23:0]);
            3'd1: ctrl_d   = ((ctrl_q & ~lane_m[12:0]) | (writedata[12:0] & lane_m[12:0])) & CTRL_WMASK;
            3'd2: raw_lo_d = (raw_lo_q & ~lane_m[27:0]) | (writedata[27:0] & lane_m[27:0]);
            3'd3: raw_hi_d = (raw_hi_q & ~lane_m[13:0]) | (writedata[13:0] & lane_m[13:0]);
            3'd4: ledr_d   = (ledr_q & ~lane_m[9:0]) | (writedata[9:0] & lane_m[9:0]);
            default: ;
         endcase
         if (address < 3'd5) wcnt_d = wcnt_q + 16'd1;
      end

      // Read mux sees the pre-write register values, so read-during-write returns old data.
      case (address)
         3'd0:    rd_mux = {8'd0, hex_q};
         3'd1:    rd_mux = {19'd0, ctrl_q};
         3'd2:    rd_mux = {4'd0, raw_lo_q};
         3'd3:    rd_mux = {18'd0, raw_hi_q};
         3'd4:    rd_mux = {22'd0, ledr_q};
         3'd5:    rd_mux = {wcnt_q, 15'd0, phase_q};
         default: rd_mux = 32'd0;
      endcase
      readdata_d = read ? rd_mux : readdata_q;

      // Segments are built from next-state values so a write shows on the edge that accepts it.
      raw_all = {raw_hi_d, raw_lo_d};
      seg_d   = '0;
      for (int k = 0; k < 6; k++) begin
         pat = ctrl_d[12] ? raw_all[7*k +: 7] : hex7(hex_d[4*k +: 4]);
         if (!ctrl_d[k] || (ctrl_d[6+k] && phase_d)) pat = 7'h7F;
         seg_d[41-7*k -: 7] = pat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hex_q      <= 24'd0;
         ctrl_q     <= 13'h003F;
         raw_lo_q   <= 28'd0;
         raw_hi_q   <= 14'd0;
         ledr_q     <= 10'd0;
         wcnt_q     <= 16'd0;
         readdata_q <= 32'd0;
         seg_q      <= {6{7'b1000000}};
      end else begin
         hex_q      <= hex_d;
         ctrl_q     <= ctrl_d;
         raw_lo_q   <= raw_lo_d;
         raw_hi_q   <= raw_hi_d;
         ledr_q     <= ledr_d;
         wcnt_q     <= wcnt_d;
         readdata_q <= readdata_d;
         seg_q      <= seg_d;
      end
   end

   assign readdata      = readdata_q;
   assign seg_conduit   = seg_q;
   assign light_conduit = ledr_q;

endmodule

// File: tb/tb_debug_display.sv
// Scoreboard bench for debug_display: stimulus queues expected responses, a monitor compares.
`timescale 1ns/1ps
module tb_debug_display;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  address = 3'd0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic [31:0] writedata = 32'd0;
   logic [3:0]  byteenable = 4'd0;
   logic [31:0] readdata;
   logic [41:0] seg_conduit;
   logic [9:0]  light_conduit;

   always #5 clk = ~clk;

   debug_display #(.BLINK_DIV(4)) dut (
      .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
      .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
      .seg_conduit(seg_conduit), .light_conduit(light_conduit)
   );

   localparam logic [6:0] S0 = 7'b1000000, S3 = 7'b0110000, S4 = 7'b0011001;
   localparam logic [6:0] SA = 7'b0001000, SB = 7'b0000011, SC = 7'b1000110;
   localparam logic [6:0] SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
   localparam logic [6:0] BL = 7'h7F;

   typedef struct {
      int          id;
      logic [41:0] seg;
      logic [9:0]  led;
      bit          chk_rd;
      logic [31:0] rdata;
   } disp_t;
   typedef struct {
      int          id;
      logic [31:0] val;
   } rd_t;

   disp_t disp_q[$];
   rd_t   rdq[$];
   disp_t dcur;
   rd_t   rcur;
   int    total = 0;
   int    bad = 0;
   bit    rd_seen = 1'b0;

   // Reference blink phase for BLINK_DIV=4: toggles every 4 cycles out of reset.
   int mcnt = 0;
   bit mph = 1'b0;
   always @(posedge clk) begin
      if (reset) begin
         mcnt <= 0;
         mph  <= 1'b0;
      end else if (mcnt == 3) begin
         mcnt <= 0;
         mph  <= ~mph;
      end else begin
         mcnt <= mcnt + 1;
      end
   end

   function automatic bit ph();
`ifdef DEBUG_DISPLAY_BLINK_EN
      return mph;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [41:0] segs(input logic [6:0] h0, h1, h2, h3, h4, h5);
      return {h0, h1, h2, h3, h4, h5};
   endfunction

   task automatic check(input int id, input string what, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL id%0d %s got=%h exp=%h", id, what, got, exp);
      end
   endtask

   always @(posedge clk) rd_seen <= read && !reset;

   always @(negedge clk) begin
      if (rd_seen) begin
         if (rdq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_read got=%h exp=none", readdata);
         end else begin
            rcur = rdq.pop_front();
            check(rcur.id, "readdata", 64'(readdata), 64'(rcur.val));
         end
      end
      if (disp_q.size() > 0) begin
         dcur = disp_q.pop_front();
         check(dcur.id, "seg_conduit", 64'(seg_conduit), 64'(dcur.seg));
         check(dcur.id, "light_conduit", 64'(light_conduit), 64'(dcur.led));
         if (dcur.chk_rd) check(dcur.id, "readdata_hold", 64'(readdata), 64'(dcur.rdata));
      end
   end

   task automatic expect_disp(input int id, input logic [41:0] s, input logic [9:0] l,
                              input bit c = 1'b0, input logic [31:0] r = 32'd0);
      disp_t d;
      d.id = id; d.seg = s; d.led = l; d.chk_rd = c; d.rdata = r;
      disp_q.push_back(d);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
      @(posedge clk); #1;
      address = a; writedata = d; byteenable = be; write = 1'b1;
      @(posedge clk); #1;
      write = 1'b0;
   endtask

   task automatic rd(input int id, input logic [2:0] a, input logic [31:0] exp);
      rd_t r;
      @(posedge clk); #1;
      address = a; read = 1'b1;
      r.id = id; r.val = exp;
      rdq.push_back(r);
      @(posedge clk); #1;
      read = 1'b0;
   endtask

   task automatic rdwr(input int id, input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] exp);
      rd_t r;
      @(posedge clk); #1;
      address = a; writedata = d; byteenable = be; write = 1'b1; read = 1'b1;
      r.id = id; r.val = exp;
      rdq.push_back(r);
      @(posedge clk); #1;
      write = 1'b0; read = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      expect_disp(1, {6{S0}}, 10'h000, 1'b1, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      rd(2, 3'd0, 32'h0);
      rd(3, 3'd1, 32'h3F);
      rd(4, 3'd5, {31'd0, ph()});

      wr(3'd0, 32'h00ABCDEF, 4'hF);
      expect_disp(10, segs(SF, SE, SD, SC, SB, SA), 10'h000);
      wr(3'd1, 32'h00000001, 4'hF);
      expect_disp(11, segs(SF, BL, BL, BL, BL, BL), 10'h000);
      rd(12, 3'd1, 32'h1);

      wr(3'd1, 32'h3F, 4'hF);
      wr(3'd0, 32'h00123456, 4'h2);
      expect_disp(20, segs(SF, SE, S4, S3, SB, SA), 10'h000);
      rd(21, 3'd0, 32'h00AB34EF);
      wr(3'd6, 32'hFFFFFFFF, 4'hF);
      rd(22, 3'd6, 32'h0);
      rd(23, 3'd0, 32'h00AB34EF);

      wr(3'd4, 32'hFFFFFFFF, 4'h1);
      expect_disp(30, segs(SF, SE, S4, S3, SB, SA), 10'h0FF);
      wr(3'd4, 32'hFFFFFFFF, 4'h2);
      expect_disp(31, segs(SF, SE, S4, S3, SB, SA), 10'h3FF);
      rd(32, 3'd4, 32'h3FF);

      wr(3'd2, 32'h01010101, 4'hF);
      wr(3'd3, 32'h00001010, 4'hF);
      expect_disp(40, segs(SF, SE, S4, S3, SB, SA), 10'h3FF);
      rd(41, 3'd2, 32'h01010101);
      wr(3'd1, 32'h0000103F, 4'hF);
      expect_disp(42, segs(7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20), 10'h3FF, 1'b1, 32'h01010101);
      wr(3'd1, 32'h00001035, 4'hF);
      expect_disp(43, segs(7'h01, BL, 7'h04, BL, 7'h10, 7'h20), 10'h3FF);

      rdwr(50, 3'd4, 32'h0, 4'hF, 32'h3FF);
      expect_disp(51, segs(7'h01, BL, 7'h04, BL, 7'h10, 7'h20), 10'h000);
      rd(52, 3'd4, 32'h0);

      wr(3'd1, 32'h0000007F, 4'hF);
      for (int i = 0; i < 10; i++) begin
         expect_disp(60 + i, segs(ph() ? BL : SF, SE, S4, S3, SB, SA), 10'h000);
         @(posedge clk); #1;
      end
`ifdef DEBUG_DISPLAY_BLINK_EN
      rd(70, 3'd1, 32'h7F);
`else
      rd(70, 3'd1, 32'h3F);
`endif
      rd(71, 3'd5, {16'h000C, 15'd0, ph()});

      wr(3'd3, 32'h00003FFF, 4'hF);
      wr(3'd1, 32'h0000103F, 4'hF);
      expect_disp(80, segs(7'h01, 7'h02, 7'h04, 7'h08, BL, BL), 10'h000);
      @(posedge clk); #1;
      address = 3'd0; writedata = 32'hFFFFFFFF; byteenable = 4'hF; write = 1'b1; reset = 1'b1;
      @(posedge clk); #1;
      expect_disp(81, {6{S0}}, 10'h000, 1'b1, 32'd0);
      @(posedge clk); #1;
      write = 1'b0; reset = 1'b0;
      rd(82, 3'd5, {31'd0, ph()});
      rd(83, 3'd0, 32'h0);
      rd(84, 3'd1, 32'h3F);

      @(posedge clk); #1;
      address = 3'd4; writedata = 32'h0; byteenable = 4'hF; write = 1'b1;
      repeat (65537) @(posedge clk);
      #1;
      write = 1'b0;
      rd(90, 3'd5, {16'h0001, 15'd0, ph()});

      repeat (3) @(posedge clk);
      if (disp_q.size() != 0 || rdq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain got=%0d/%0d exp=0/0", disp_q.size(), rdq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
